capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_pkg.sv | 17 +
 rtl/capture_ctrl_if.sv | 34 +++
 rtl/smpl_decim.sv | 40 ++++
 rtl/capture_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_capture_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_pkg.sv
// Shared types and default sizing for the sample-capture controller.
// ENTRIES/LOG2 defaults match the standard build; DE-0 uses ENTRIES=12288.
package capture_pkg;

    localparam int ENTRIES_DEF = 384;
    localparam int LOG2_DEF    = 9;
    localparam int DECIM_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } cap_state_e;

endpackage

// File: rtl/capture_ctrl_if.sv
// Control/status bundle between cmd_cfg, trigger unit, sample RAM and capture_ctrl.
// slave is the controller side; master is the side driving samples and configuration.
interface capture_ctrl_if
    import capture_pkg::*;
#(
    parameter int LOG2    = LOG2_DEF,
    parameter int DECIM_W = DECIM_W_DEF
);

    logic               wrt_smpl;
    logic               run;
    logic               capture_done;
    logic               cont;
    logic               triggered;
    logic [LOG2-1:0]    trig_pos;
    logic [DECIM_W-1:0] decim;

    logic               we;
    logic [LOG2-1:0]    waddr;
    logic               set_capture_done;
    logic               armed;
    logic [LOG2-1:0]    trig_addr;

    modport master (
        output wrt_smpl, run, capture_done, cont, triggered, trig_pos, decim,
        input  we, waddr, set_capture_done, armed, trig_addr
    );

    modport slave (
        input  wrt_smpl, run, capture_done, cont, triggered, trig_pos, decim,
        output we, waddr, set_capture_done, armed, trig_addr
    );

endinterface

// File: rtl/smpl_decim.sv
// Sample prescaler: passes the first of every 2^decim wrt_smpl pulses, combinationally.
// clr restarts the group so the next pulse is accepted; clr wins over a coincident pulse.
module smpl_decim
    import capture_pkg::*;
#(
    parameter int DECIM_W = DECIM_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               wrt_smpl,
    input  logic [DECIM_W-1:0] decim,
    output logic               accept
);

    // Wide enough that the largest exponent gives a full-period wrap.
    localparam int CNT_W = (1 << DECIM_W) - 1;

    logic [CNT_W-1:0] cnt_q, cnt_d, mask;

    always_comb begin
        mask   = ~({CNT_W{1'b1}} << decim);
        accept = wrt_smpl && ((cnt_q & mask) == '0);
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wrt_smpl) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Circular-buffer capture sequencer: pre-trigger fill, arm, post-trigger count, done handshake.
// we/set_capture_done are combinational in the sample cycle; CAPTURE_DECIM_EN enables smpl_decim.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int LOG2    = LOG2_DEF,
    parameter int DECIM_W = DECIM_W_DEF
) (
    input logic           clk,
    input logic           rst,
    capture_ctrl_if.slave cif
);

    localparam int              CNT_W     = LOG2 + 1;
    localparam logic [LOG2-1:0] ADDR_LAST = LOG2'(ENTRIES - 1);
    localparam logic [CNT_W-1:0] ENTRIES_C = CNT_W'(ENTRIES);

    cap_state_e       state_q, state_d;
    logic [LOG2-1:0]  waddr_q, waddr_d;
    logic [LOG2-1:0]  trig_addr_q, trig_addr_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [LOG2-1:0]  post_cnt_q, post_cnt_d;

    logic [LOG2-1:0]  tpos;
    logic [CNT_W-1:0] fill_thresh;
    logic [LOG2-1:0]  waddr_inc;
    logic             accept;
    logic             decim_clr;
    logic             we_c;
    logic             set_done_c;

`ifdef CAPTURE_DECIM_EN
    smpl_decim #(
        .DECIM_W (DECIM_W)
    ) u_decim (
        .clk      (clk),
        .rst      (rst),
        .clr      (decim_clr),
        .wrt_smpl (cif.wrt_smpl),
        .decim    (cif.decim),
        .accept   (accept)
    );
`else
    logic [DECIM_W:0] decim_unused;
    assign decim_unused = {decim_clr, cif.decim};
    assign accept       = cif.wrt_smpl;
`endif

    always_comb begin
        tpos        = (cif.trig_pos > ADDR_LAST) ? ADDR_LAST : cif.trig_pos;
        fill_thresh = ENTRIES_C - {1'b0, tpos};
        waddr_inc   = (waddr_q == ADDR_LAST) ? '0 : waddr_q + LOG2'(1);
    end

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        trig_addr_d = trig_addr_q;
        armed_d     = armed_q;
        fill_cnt_d  = fill_cnt_q;
        post_cnt_d  = post_cnt_q;
        we_c        = 1'b0;
        set_done_c  = 1'b0;
        decim_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                armed_d = 1'b0;
                if (cif.run) begin
                    state_d    = FILL;
                    waddr_d    = '0;
                    fill_cnt_d = '0;
                    post_cnt_d = '0;
                    decim_clr  = 1'b1;
                end
            end

            FILL: begin
                if (!cif.run) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end else begin
                    if (accept) begin
                        we_c    = 1'b1;
                        waddr_d = waddr_inc;
                        if (fill_cnt_q != ENTRIES_C) begin
                            fill_cnt_d = fill_cnt_q + CNT_W'(1);
                        end
                    end
                    // Compared every cycle so a lowered trig_pos arms without waiting for a sample.
                    if (fill_cnt_d >= fill_thresh) begin
                        state_d = ARMED;
                        armed_d = 1'b1;
                    end
                end
            end

            ARMED: begin
                if (!cif.run) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end else if (cif.triggered && (tpos == '0)) begin
                    state_d    = DONE;
                    armed_d    = 1'b0;
                    set_done_c = 1'b1;
                end else if (cif.triggered) begin
                    state_d     = POST;
                    trig_addr_d = waddr_q;
                    post_cnt_d  = {{(LOG2-1){1'b0}}, accept};
                    if (accept) begin
                        we_c    = 1'b1;
                        waddr_d = waddr_inc;
                    end
                end else if (accept) begin
                    we_c    = 1'b1;
                    waddr_d = waddr_inc;
                end
            end

            POST: begin
                if (!cif.run) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end else if (post_cnt_q >= tpos) begin
                    state_d    = DONE;
                    armed_d    = 1'b0;
                    set_done_c = 1'b1;
                end else if (accept) begin
                    we_c       = 1'b1;
                    waddr_d    = waddr_inc;
                    post_cnt_d = post_cnt_q + LOG2'(1);
                end
            end

            DONE: begin
                // waddr holds here: after a full capture it points at the oldest sample.
                if (!cif.capture_done) begin
                    if (cif.run && cif.cont) begin
                        state_d    = FILL;
                        waddr_d    = '0;
                        fill_cnt_d = '0;
                        post_cnt_d = '0;
                        decim_clr  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                armed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            trig_addr_q <= '0;
            armed_q     <= 1'b0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            trig_addr_q <= trig_addr_d;
            armed_q     <= armed_d;
            fill_cnt_q  <= fill_cnt_d;
            post_cnt_q  <= post_cnt_d;
        end
    end

    assign cif.we               = we_c & ~rst;
    assign cif.set_capture_done = set_done_c & ~rst;
    assign cif.waddr            = waddr_q;
    assign cif.armed            = armed_q;
    assign cif.trig_addr        = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboarded bench for capture_ctrl: expected write addresses queued at stimulus time,
// popped on every we; the host side of the capture_done bit is modelled in step().
module tb_capture_ctrl;
    import capture_pkg::*;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
    localparam int DECIM_W = 4;

    logic clk = 1'b0;
    logic rst;

    capture_ctrl_if #(.LOG2(LOG2), .DECIM_W(DECIM_W)) cif ();

    capture_ctrl #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2),
        .DECIM_W (DECIM_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cif (cif)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];
    int   done_pulses = 0;
    int   we_cnt = 0;
    int   t;
    int   d0;
    int   exp_n;
    logic last_we;
    logic last_sc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs are set by the caller just after a negedge; outputs sampled 1ns later.
    task automatic step();
        int e;
        #1;
        last_we = cif.we;
        last_sc = cif.set_capture_done;
        if (cif.we === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check_val("spurious_we", 32'(cif.we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("waddr", 32'(cif.waddr), 32'(e));
            end
        end
        if (cif.set_capture_done === 1'b1) done_pulses++;
        @(negedge clk);
        if (last_sc) cif.capture_done = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        cif.wrt_smpl     = 1'b0;
        cif.run          = 1'b0;
        cif.capture_done = 1'b0;
        cif.cont         = 1'b0;
        cif.triggered    = 1'b0;
        cif.trig_pos     = '0;
        cif.decim        = '0;
        repeat (3) @(negedge clk);
        step();
        check_val("rst_we",        32'(last_we),       32'd0);
        check_val("rst_sc",        32'(last_sc),       32'd0);
        check_val("rst_waddr",     32'(cif.waddr),     32'd0);
        check_val("rst_armed",     32'(cif.armed),     32'd0);
        check_val("rst_trig_addr", 32'(cif.trig_addr), 32'd0);
        rst = 1'b0;

        // Basic capture: trig_pos=100, trigger on sample 401.
        cif.trig_pos = 9'd100;
        cif.run      = 1'b1;
        step();
        d0 = done_pulses;
        t  = 0;
        while (done_pulses == d0 && t < 600) begin
            cif.wrt_smpl  = 1'b1;
            cif.triggered = (t >= 400);
            if (t < 500) exp_q.push_back(t % ENTRIES);
            step();
            if (t == 282) check_val("s1_armed_before", 32'(cif.armed), 32'd0);
            if (t == 283) check_val("s1_armed_284",    32'(cif.armed), 32'd1);
            t++;
        end
        check_val("s1_done_cycle", 32'(t), 32'd501);
        repeat (3) step();
        check_val("s1_waddr",     32'(cif.waddr),     32'd116);
        check_val("s1_trig_addr", 32'(cif.trig_addr), 32'd16);
        check_val("s1_armed",     32'(cif.armed),     32'd0);
        check_val("s1_pulses",    32'(done_pulses),   32'd1);
        check_val("s1_sb_empty",  32'(exp_q.size()),  32'd0);

        cif.run          = 1'b0;
        cif.capture_done = 1'b0;
        cif.wrt_smpl     = 1'b0;
        cif.triggered    = 1'b0;
        step();

        // trig_pos beyond depth clips; then trig_pos=0 trigger finishes with no write.
        cif.trig_pos = 9'd500;
        cif.cont     = 1'b1;
        cif.run      = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            cif.wrt_smpl = 1'b1;
            exp_q.push_back(i);
            step();
            if (i == 0) check_val("s2_armed_clip", 32'(cif.armed), 32'd1);
        end
        check_val("s2_waddr_pre", 32'(cif.waddr), 32'd6);
        cif.trig_pos  = 9'd0;
        cif.triggered = 1'b1;
        step();
        check_val("s2_tpos0_sc",    32'(last_sc),      32'd1);
        check_val("s2_tpos0_we",    32'(last_we),      32'd0);
        check_val("s2_pulses",      32'(done_pulses),  32'd2);
        check_val("s2_waddr_done",  32'(cif.waddr),    32'd6);
        check_val("s2_armed",       32'(cif.armed),    32'd0);

        // Continuous re-arm with triggered held high from the start.
        cif.capture_done = 1'b0;
        cif.trig_pos     = 9'd380;
        cif.wrt_smpl     = 1'b0;
        step();
        check_val("s3_cont_restart", 32'(cif.waddr), 32'd0);
        check_val("s3_armed0",       32'(cif.armed), 32'd0);
        d0 = done_pulses;
        t  = 0;
        while (done_pulses == d0 && t < 500) begin
            cif.wrt_smpl = 1'b1;
            if (t < 384) exp_q.push_back(t);
            step();
            if (t == 2) check_val("s3_armed_before", 32'(cif.armed), 32'd0);
            if (t == 3) check_val("s3_armed_at",     32'(cif.armed), 32'd1);
            t++;
        end
        check_val("s3_done_cycle", 32'(t),             32'd385);
        check_val("s3_trig_addr",  32'(cif.trig_addr), 32'd4);
        check_val("s3_waddr",      32'(cif.waddr),     32'd0);
        check_val("s3_pulses",     32'(done_pulses),   32'd3);
        check_val("s3_sb_empty",   32'(exp_q.size()),  32'd0);

        // cont=0: release goes to IDLE even with run high, so the next pulse is not written.
        cif.cont         = 1'b0;
        cif.capture_done = 1'b0;
        cif.triggered    = 1'b0;
        cif.wrt_smpl     = 1'b0;
        step();
        cif.wrt_smpl = 1'b1;
        step();
        check_val("s3_cont0_idle", 32'(last_we), 32'd0);

        // Abort mid-POST.
        for (int i = 0; i < 12; i++) begin
            cif.wrt_smpl  = 1'b1;
            cif.triggered = (i >= 6);
            exp_q.push_back(i);
            step();
        end
        check_val("s4_trig_addr", 32'(cif.trig_addr), 32'd6);
        check_val("s4_waddr_pre", 32'(cif.waddr),     32'd12);
        cif.run = 1'b0;
        step();
        check_val("s4_abort_we",    32'(last_we),     32'd0);
        check_val("s4_abort_sc",    32'(last_sc),     32'd0);
        check_val("s4_abort_armed", 32'(cif.armed),   32'd0);
        check_val("s4_abort_waddr", 32'(cif.waddr),   32'd12);
        step();
        check_val("s4_idle_waddr",  32'(cif.waddr),   32'd12);
        check_val("s4_pulses",      32'(done_pulses), 32'd3);

        // Reset mid-FILL.
        cif.triggered = 1'b0;
        cif.trig_pos  = 9'd100;
        cif.run       = 1'b1;
        cif.wrt_smpl  = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            cif.wrt_smpl = 1'b1;
            exp_q.push_back(i);
            step();
        end
        rst = 1'b1;
        step();
        check_val("s5_rst_we",        32'(last_we),       32'd0);
        check_val("s5_rst_sc",        32'(last_sc),       32'd0);
        check_val("s5_rst_waddr",     32'(cif.waddr),     32'd0);
        check_val("s5_rst_armed",     32'(cif.armed),     32'd0);
        check_val("s5_rst_trig_addr", 32'(cif.trig_addr), 32'd0);
        rst          = 1'b0;
        cif.run      = 1'b0;
        cif.wrt_smpl = 1'b0;
        step();

        // Decimation: decim=2 accepts one pulse in four when the feature is built in.
`ifdef CAPTURE_DECIM_EN
        exp_n = 4;
`else
        exp_n = 16;
`endif
        cif.decim    = 4'd2;
        cif.trig_pos = 9'd0;
        cif.run      = 1'b1;
        step();
        we_cnt = 0;
        for (int i = 0; i < exp_n; i++) exp_q.push_back(i);
        for (int i = 0; i < 16; i++) begin
            cif.wrt_smpl = 1'b1;
            step();
        end
        check_val("s6_decim_we_cnt", 32'(we_cnt),       32'(exp_n));
        check_val("s6_sb_empty",     32'(exp_q.size()), 32'd0);
        cif.run      = 1'b0;
        cif.wrt_smpl = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
